// File: rtl/lower_layer_4_4_merge_if.sv
// Handshake/bus bundle for the 4+4 merge stage: run load side and merged output stream.
interface lower_layer_4_4_merge_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned RUN_LEN = 4
);
    logic                       load;
    logic [RUN_LEN*DATA_W-1:0]  left_data;
    logic [RUN_LEN*TAG_W-1:0]   left_tag;
    logic [RUN_LEN*DATA_W-1:0]  right_data;
    logic [RUN_LEN*TAG_W-1:0]   right_tag;
    logic                       out_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [TAG_W-1:0]           out_tag;
    logic                       out_last;
    logic                       busy;
    logic                       done;

    modport master (
        output load, left_data, left_tag, right_data, right_tag, out_ready,
        input  out_valid, out_data, out_tag, out_last, busy, done
    );

    modport slave (
        input  load, left_data, left_tag, right_data, right_tag, out_ready,
        output out_valid, out_data, out_tag, out_last, busy, done
    );
endinterface

// File: rtl/lower_layer_4_4_merge.sv
// Merges two ascending RUN_LEN-entry (distance, label) runs into one ascending stream; ties take left.
// Optional LL44_SORT_CHECK_EN adds err_unsorted, flagging an unsorted input run at capture.
module lower_layer_4_4_merge #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lower_layer_4_4_merge_if.slave bus
`ifdef LL44_SORT_CHECK_EN
    ,
    output logic                   err_unsorted
`endif
);
    localparam int unsigned IdxW  = $clog2(RUN_LEN);
    localparam int unsigned PtrW  = $clog2(RUN_LEN) + 1;
    localparam int unsigned CntW  = $clog2(2 * RUN_LEN) + 1;
    localparam logic [PtrW-1:0] PtrEnd = PtrW'(RUN_LEN);
    localparam logic [CntW-1:0] OutLen = CntW'(2 * RUN_LEN);

    typedef enum logic [0:0] {StIdle, StMerge} state_e;

    state_e                             state_q, state_d;
    logic [RUN_LEN-1:0][DATA_W-1:0]     l_data_q, l_data_d, r_data_q, r_data_d;
    logic [RUN_LEN-1:0][TAG_W-1:0]      l_tag_q, l_tag_d, r_tag_q, r_tag_d;
    logic [PtrW-1:0]                    lp_q, lp_d, rp_q, rp_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic                               out_valid_q, out_valid_d;
    logic                               out_last_q, out_last_d;
    logic [DATA_W-1:0]                  out_data_q, out_data_d;
    logic [TAG_W-1:0]                   out_tag_q, out_tag_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;

    logic [DATA_W-1:0] l_head, r_head;
    logic              take_left;
    logic [CntW-1:0]   cnt_inc;

`ifdef LL44_SORT_CHECK_EN
    logic                           err_q, err_d;
    logic [RUN_LEN-1:0][DATA_W-1:0] l_in, r_in;
    logic                           unsorted_in;

    always_comb begin
        l_in        = bus.left_data;
        r_in        = bus.right_data;
        unsorted_in = 1'b0;
        for (int i = 0; i < int'(RUN_LEN) - 1; i++) begin
            if (l_in[i] > l_in[i+1] || r_in[i] > r_in[i+1]) begin
                unsorted_in = 1'b1;
            end
        end
    end

    assign err_unsorted = err_q;
`endif

    // Heads are only consulted while their pointer is below RUN_LEN, so the low bits suffice.
    assign l_head  = l_data_q[lp_q[IdxW-1:0]];
    assign r_head  = r_data_q[rp_q[IdxW-1:0]];
    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        if (lp_q == PtrEnd) begin
            take_left = 1'b0;
        end else if (rp_q == PtrEnd) begin
            take_left = 1'b1;
        end else begin
            take_left = (l_head <= r_head);
        end
    end

    always_comb begin
        state_d     = state_q;
        l_data_d    = l_data_q;
        r_data_d    = r_data_q;
        l_tag_d     = l_tag_q;
        r_tag_d     = r_tag_q;
        lp_d        = lp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        busy_d      = busy_q;
        done_d      = done_q;
`ifdef LL44_SORT_CHECK_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    l_data_d    = bus.left_data;
                    r_data_d    = bus.right_data;
                    l_tag_d     = bus.left_tag;
                    r_tag_d     = bus.right_tag;
                    lp_d        = '0;
                    rp_d        = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
`ifdef LL44_SORT_CHECK_EN
                    err_d       = unsorted_in;
`endif
                    state_d     = StMerge;
                end
            end
            StMerge: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end else if ((!out_valid_q || bus.out_ready) && (cnt_q < OutLen)) begin
                    if (take_left) begin
                        out_data_d = l_head;
                        out_tag_d  = l_tag_q[lp_q[IdxW-1:0]];
                        lp_d       = lp_q + PtrW'(1);
                    end else begin
                        out_data_d = r_head;
                        out_tag_d  = r_tag_q[rp_q[IdxW-1:0]];
                        rp_d       = rp_q + PtrW'(1);
                    end
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_inc == OutLen);
                    cnt_d       = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            l_data_q    <= '0;
            r_data_q    <= '0;
            l_tag_q     <= '0;
            r_tag_q     <= '0;
            lp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LL44_SORT_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            l_data_q    <= l_data_d;
            r_data_q    <= r_data_d;
            l_tag_q     <= l_tag_d;
            r_tag_q     <= r_tag_d;
            lp_q        <= lp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef LL44_SORT_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_lower_layer_4_4_merge.sv
// Directed-vector bench for lower_layer_4_4_merge: ordering, ties, exhaustion, stalls, protocol.
module tb_lower_layer_4_4_merge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    lower_layer_4_4_merge_if #(.DATA_W(16), .TAG_W(4), .RUN_LEN(4)) bus ();

`ifdef LL44_SORT_CHECK_EN
    logic err_unsorted;
`endif

    lower_layer_4_4_merge #(.DATA_W(16), .TAG_W(4), .RUN_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LL44_SORT_CHECK_EN
        ,
        .err_unsorted (err_unsorted)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_runs(input logic [63:0] ld, input logic [63:0] rd,
                            input logic [15:0] lt, input logic [15:0] rt);
        bus.left_data  = ld;
        bus.right_data = rd;
        bus.left_tag   = lt;
        bus.right_tag  = rt;
    endtask

    // Pulses load for one cycle; returns in the cycle right after the capture edge.
    task automatic do_load();
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("busy_after_load", 32'(bus.busy), 1);
        check("done_after_load", 32'(bus.done), 0);
        check("no_valid_yet", 32'(bus.out_valid), 0);
    endtask

    task automatic run_stream(input logic [127:0] ed, input logic [31:0] et,
                              input int stall_k, input int stall_n, input int pulse_k);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == pulse_k) begin
                bus.load      = 1'b1;
                bus.left_data = '1;
            end
            if (k == pulse_k + 1) bus.load = 1'b0;
            check($sformatf("valid[%0d]", k), 32'(bus.out_valid), 1);
            check($sformatf("data[%0d]", k), 32'(bus.out_data), 32'(ed[k*16 +: 16]));
            check($sformatf("tag[%0d]", k), 32'(bus.out_tag), 32'(et[k*4 +: 4]));
            check($sformatf("last[%0d]", k), 32'(bus.out_last), (k == 7) ? 1 : 0);
            check($sformatf("busy[%0d]", k), 32'(bus.busy), 1);
            if (k == stall_k) begin
                bus.out_ready = 1'b0;
                for (int j = 0; j < stall_n; j++) begin
                    tick();
                    check("stall_valid", 32'(bus.out_valid), 1);
                    check("stall_data", 32'(bus.out_data), 32'(ed[k*16 +: 16]));
                    check("stall_tag", 32'(bus.out_tag), 32'(et[k*4 +: 4]));
                end
                bus.out_ready = 1'b1;
            end
            tick();
        end
        check("done_end", 32'(bus.done), 1);
        check("busy_end", 32'(bus.busy), 0);
        check("valid_end", 32'(bus.out_valid), 0);
        check("last_end", 32'(bus.out_last), 0);
    endtask

    // Expected streams, entry 0 in the low bits.
    localparam logic [127:0] BasicD = {16'd9, 16'd8, 16'd7, 16'd6, 16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [31:0]  BasicT = {4'd3, 4'd11, 4'd10, 4'd2, 4'd1, 4'd9, 4'd8, 4'd0};
    localparam logic [127:0] TieD   = {8{16'd5}};
    localparam logic [31:0]  TieT   = {4'd11, 4'd10, 4'd9, 4'd8, 4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [127:0] ExhD   = {16'd13, 16'd12, 16'd11, 16'd10, 16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [15:0]  TagsL  = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [15:0]  TagsR  = {4'd11, 4'd10, 4'd9, 4'd8};

    task automatic load_basic();
        set_runs({16'd9, 16'd6, 16'd4, 16'd1}, {16'd8, 16'd7, 16'd3, 16'd2}, TagsL, TagsR);
    endtask

    initial begin
        bus.load      = 1'b1;
        bus.out_ready = 1'b1;
        load_basic();

        // Reset with load asserted throughout.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_last", 32'(bus.out_last), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_tag", 32'(bus.out_tag), 0);
        bus.load = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_valid", 32'(bus.out_valid), 0);

        // Basic merge.
        do_load();
        run_stream(BasicD, BasicT, -1, 0, -1);

        // Ties, loaded in the same cycle done is high.
        set_runs({4{16'd5}}, {4{16'd5}}, TagsL, TagsR);
        do_load();
        run_stream(TieD, TieT, -1, 0, -1);

        // Left exhausted first.
        set_runs({16'd4, 16'd3, 16'd2, 16'd1}, {16'd13, 16'd12, 16'd11, 16'd10}, TagsL, TagsR);
        do_load();
        run_stream(ExhD, TieT, -1, 0, -1);

        // Backpressure on the 3rd element for 3 cycles.
        load_basic();
        do_load();
        run_stream(BasicD, BasicT, 2, 3, -1);

        // Load pulse with junk data mid-merge.
        load_basic();
        do_load();
        run_stream(BasicD, BasicT, -1, 0, 2);

        // Reset mid-stream.
        load_basic();
        do_load();
        tick();
        tick();
        tick();
        check("mid_valid_before", 32'(bus.out_valid), 1);
        check("mid_data_before", 32'(bus.out_data), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        tick();
        check("mid_rst_stays_idle", 32'(bus.out_valid), 0);

        // A fresh merge after the abandoned one starts from the beginning.
        load_basic();
        do_load();
        run_stream(BasicD, BasicT, -1, 0, -1);

`ifdef LL44_SORT_CHECK_EN
        set_runs({16'd6, 16'd5, 16'd2, 16'd3}, {16'd8, 16'd7, 16'd3, 16'd2}, TagsL, TagsR);
        do_load();
        check("err_set", 32'(err_unsorted), 1);
        for (int i = 0; i < 10; i++) tick();
        check("err_sticky", 32'(err_unsorted), 1);
        check("err_done", 32'(bus.done), 1);
        load_basic();
        do_load();
        check("err_clear", 32'(err_unsorted), 0);
        run_stream(BasicD, BasicT, -1, 0, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
